// File: rtl/comparador_search_ctrl_if.sv
// Start/flag/result bundle between the successive-approximation search controller
// and its environment (the comparator plus whoever requests searches).
interface comparador_search_ctrl_if #(
  parameter int N = 8
);
  localparam int SW = $clog2(N + 2);

  logic          start_in;
  logic          gt_in;
  logic          lt_in;
  logic          eq_in;
  logic [N-1:0]  guess_out;
  logic          busy_out;
  logic          done_out;
  logic [N-1:0]  result_out;
  logic [SW-1:0] steps_out;
  logic          error_out;

  modport master (
    output start_in, gt_in, lt_in, eq_in,
    input  guess_out, busy_out, done_out, result_out, steps_out, error_out
  );

  modport slave (
    input  start_in, gt_in, lt_in, eq_in,
    output guess_out, busy_out, done_out, result_out, steps_out, error_out
  );
endinterface

// File: rtl/comparador_search_ctrl.sv
// Binary search for the comparator's a operand: one comparison per SETTLE_CYC cycles,
// done pulses k*SETTLE_CYC cycles after start; start is ignored unless idle.
module comparador_search_ctrl #(
  parameter int N          = 8,
  parameter int SETTLE_CYC = 1
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  comparador_search_ctrl_if.slave bus
);
  localparam int SW = $clog2(N + 2);
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [N:0]    HI_INIT    = {1'b0, {N{1'b1}}};
  localparam logic [N:0]    ONE_W      = 1;
  localparam logic [N-1:0]  GUESS_INIT = {1'b0, {(N-1){1'b1}}};
  localparam logic [CW-1:0] CNT_INIT   = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE    = 1;
  localparam logic [SW-1:0] STEP_ONE   = 1;

  logic [1:0]    r_state;
  logic [N:0]    r_lo;
  logic [N:0]    r_hi;
  logic [N-1:0]  r_guess;
  logic [N-1:0]  r_result;
  logic [SW-1:0] r_steps;
  logic [SW-1:0] r_steps_out;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_error;

  logic [2:0]    w_flags;
  logic          w_gt_only;
  logic          w_lt_only;
  logic          w_eq_only;
  logic [N:0]    w_guess_ext;
  logic [N:0]    w_lo_gt;
  logic [N:0]    w_hi_lt;
  logic [N:0]    w_new_lo;
  logic [N:0]    w_new_hi;
  logic          w_empty;
  logic [N-1:0]  w_next_guess;
  logic [SW-1:0] w_steps_inc;

  assign w_flags     = {bus.gt_in, bus.lt_in, bus.eq_in};
  assign w_gt_only   = (w_flags == 3'b100);
  assign w_lt_only   = (w_flags == 3'b010);
  assign w_eq_only   = (w_flags == 3'b001);
  assign w_guess_ext = {1'b0, r_guess};
  assign w_lo_gt     = w_guess_ext + ONE_W;
  assign w_hi_lt     = w_guess_ext - ONE_W;
  assign w_new_lo    = w_gt_only ? w_lo_gt : r_lo;
  assign w_new_hi    = w_lt_only ? w_hi_lt : r_hi;

  // guess-1 wraps when guess==0, so the lt case tests lo>=guess instead of lo>guess-1
  assign w_empty = w_gt_only ? (w_lo_gt > r_hi) :
                   w_lt_only ? (r_lo >= w_guess_ext) : 1'b0;

  assign w_next_guess = N'(w_new_lo + ((w_new_hi - w_new_lo) >> 1));
  assign w_steps_inc  = r_steps + STEP_ONE;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_lo        <= '0;
      r_hi        <= HI_INIT;
      r_guess     <= '0;
      r_result    <= '0;
      r_steps     <= '0;
      r_steps_out <= '0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_in) begin
            r_lo     <= '0;
            r_hi     <= HI_INIT;
            r_guess  <= GUESS_INIT;
            r_steps  <= '0;
            r_error  <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b1;
            r_cnt    <= CNT_INIT;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            r_steps <= w_steps_inc;
            if ((w_gt_only || w_lt_only) && !w_empty) begin
              r_lo    <= w_new_lo;
              r_hi    <= w_new_hi;
              r_guess <= w_next_guess;
              r_cnt   <= CNT_INIT;
            end else begin
              // eq, empty range and invalid flag patterns all terminate here
              r_error     <= !w_eq_only;
              r_result    <= r_guess;
              r_steps_out <= w_steps_inc;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.guess_out  = r_guess;
  assign bus.busy_out   = r_busy;
  assign bus.done_out   = r_done;
  assign bus.result_out = r_result;
  assign bus.steps_out  = r_steps_out;
  assign bus.error_out  = r_error;
endmodule

// File: tb/tb_comparador_search_ctrl.sv
// Randomized bench for comparador_search_ctrl: three instances (N=2/S=1, N=8/S=1, N=8/S=3)
// checked cycle by cycle against an integer binary-search model.
module tb_comparador_search_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start_d [3];
  logic [2:0] fl_d    [3];
  logic [7:0] o_guess [3];
  logic [7:0] o_res   [3];
  logic [3:0] o_steps [3];
  logic       o_busy  [3];
  logic       o_done  [3];
  logic       o_err   [3];

  int n_of [3] = '{2, 8, 8};
  int s_of [3] = '{1, 1, 3};

  comparador_search_ctrl_if #(.N(2)) if0 ();
  comparador_search_ctrl_if #(.N(8)) if1 ();
  comparador_search_ctrl_if #(.N(8)) if2 ();

  comparador_search_ctrl #(.N(2), .SETTLE_CYC(1)) u0 (.clk_in(clk), .rst_in(rst), .bus(if0));
  comparador_search_ctrl #(.N(8), .SETTLE_CYC(1)) u1 (.clk_in(clk), .rst_in(rst), .bus(if1));
  comparador_search_ctrl #(.N(8), .SETTLE_CYC(3)) u2 (.clk_in(clk), .rst_in(rst), .bus(if2));

  assign if0.start_in = start_d[0];
  assign if0.gt_in    = fl_d[0][2];
  assign if0.lt_in    = fl_d[0][1];
  assign if0.eq_in    = fl_d[0][0];
  assign if1.start_in = start_d[1];
  assign if1.gt_in    = fl_d[1][2];
  assign if1.lt_in    = fl_d[1][1];
  assign if1.eq_in    = fl_d[1][0];
  assign if2.start_in = start_d[2];
  assign if2.gt_in    = fl_d[2][2];
  assign if2.lt_in    = fl_d[2][1];
  assign if2.eq_in    = fl_d[2][0];

  assign o_guess[0] = 8'(if0.guess_out);
  assign o_guess[1] = if1.guess_out;
  assign o_guess[2] = if2.guess_out;
  assign o_res[0]   = 8'(if0.result_out);
  assign o_res[1]   = if1.result_out;
  assign o_res[2]   = if2.result_out;
  assign o_steps[0] = 4'(if0.steps_out);
  assign o_steps[1] = if1.steps_out;
  assign o_steps[2] = if2.steps_out;
  assign o_busy[0]  = if0.busy_out;
  assign o_busy[1]  = if1.busy_out;
  assign o_busy[2]  = if2.busy_out;
  assign o_done[0]  = if0.done_out;
  assign o_done[1]  = if1.done_out;
  assign o_done[2]  = if2.done_out;
  assign o_err[0]   = if0.error_out;
  assign o_err[1]   = if1.error_out;
  assign o_err[2]   = if2.error_out;

  int         exp_seq [$];
  logic [2:0] exp_fl  [$];
  logic [2:0] force_q [$];
  int         exp_k;
  int         exp_res;
  int         exp_err;
  int         cur_k;
  int         t;
  logic       chk_en = 1'b0;
  logic       glitch = 1'b0;
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d, inst=%0d)", nm, act, req, t, cur_k);
    end
  endtask

  // Plain-integer binary search; force_q overrides the comparator answer per step.
  task automatic model(input int n, input int a);
    int lo;
    int hi;
    lo = 0;
    hi = (1 << n) - 1;
    exp_seq.delete();
    exp_fl.delete();
    exp_err = 0;
    exp_res = 0;
    for (int i = 0; i < 16; i++) begin
      int g;
      logic [2:0] f;
      g = lo + (hi - lo) / 2;
      if (i < force_q.size()) f = force_q[i];
      else f = {a > g, a < g, a == g};
      exp_seq.push_back(g);
      exp_fl.push_back(f);
      if (f == 3'b001) begin
        exp_res = g;
        break;
      end else if (f == 3'b100) lo = g + 1;
      else if (f == 3'b010) hi = g - 1;
      else begin
        exp_err = 1;
        exp_res = g;
        break;
      end
      if (lo > hi) begin
        exp_err = 1;
        exp_res = g;
        break;
      end
    end
    exp_k = exp_seq.size();
  endtask

  task automatic drive(input int k);
    logic [2:0] bad [5];
    int s;
    s = s_of[k];
    bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    if (t >= exp_k * s) fl_d[k] = 3'b000;
    else if (glitch && ((t + 1) % s != 0)) fl_d[k] = bad[$urandom_range(4)];
    else fl_d[k] = exp_fl[t / s];
  endtask

  task automatic run(input int k, input int a, input logic gl, input logic poke);
    int s;
    s = s_of[k];
    model(n_of[k], a);
    glitch = gl;
    @(negedge clk);
    start_d[k] = 1'b1;
    @(posedge clk);
    #1;
    start_d[k] = 1'b0;
    cur_k = k;
    t = 0;
    chk_en = 1'b1;
    drive(k);
    while (t <= exp_k * s) begin
      @(posedge clk);
      #1;
      t++;
      start_d[k] = poke && (t == 1 || t == exp_k * s);
      drive(k);
    end
    @(negedge clk);
    #1 chk_en = 1'b0;
    start_d[k] = 1'b0;
  endtask

  task automatic chk_zero(input int k, input string tag);
    chk({tag, "_guess"}, int'(o_guess[k]), 0);
    chk({tag, "_busy"},  int'(o_busy[k]),  0);
    chk({tag, "_done"},  int'(o_done[k]),  0);
    chk({tag, "_result"}, int'(o_res[k]),  0);
    chk({tag, "_steps"}, int'(o_steps[k]), 0);
    chk({tag, "_error"}, int'(o_err[k]),   0);
  endtask

  // Single compare process: every cycle of a search plus the idle cycle after it.
  always @(negedge clk) begin
    if (chk_en) begin
      int k;
      int s;
      int last;
      k = cur_k;
      s = s_of[k];
      last = exp_k * s;
      if (t < last) begin
        chk("guess", int'(o_guess[k]), exp_seq[t / s]);
        chk("busy", int'(o_busy[k]), 1);
        chk("done", int'(o_done[k]), 0);
        chk("result_clr", int'(o_res[k]), 0);
        chk("error_clr", int'(o_err[k]), 0);
      end else begin
        chk("guess_hold", int'(o_guess[k]), exp_seq[exp_k - 1]);
        chk("busy_end", int'(o_busy[k]), 0);
        chk("done_end", int'(o_done[k]), (t == last) ? 1 : 0);
        chk("result", int'(o_res[k]), exp_res);
        chk("steps", int'(o_steps[k]), exp_k);
        chk("error", int'(o_err[k]), exp_err);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      start_d[k] = 1'b0;
      fl_d[k] = 3'b000;
    end
    t = 0;
    cur_k = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    chk_zero(2, "rst2");

    force_q.delete();
    model(2, 3);
    chk("pin_a3_k", exp_k, 3);
    chk("pin_a3_seq", exp_seq[0] * 100 + exp_seq[1] * 10 + exp_seq[2], 123);
    model(2, 0);
    chk("pin_a0_k", exp_k, 2);
    chk("pin_a0_seq", exp_seq[0] * 10 + exp_seq[1], 10);
    model(8, 127);
    chk("pin_a127_k", exp_k, 1);
    model(8, 200);
    chk("pin_a200_res", exp_res, 200);
    chk("pin_a200_le9", int'(exp_k <= 9), 1);
    force_q = '{3'b110};
    model(2, 1);
    chk("pin_gtlt_err", exp_err * 10 + exp_k, 11);
    force_q = '{3'b010, 3'b010};
    model(2, 1);
    chk("pin_lt0_err", exp_err * 10 + exp_res, 10);
    force_q.delete();

    run(0, 3, 1'b0, 1'b0);
    run(0, 0, 1'b0, 1'b1);
    run(1, 127, 1'b0, 1'b0);
    run(2, 200, 1'b1, 1'b1);
    run(1, 255, 1'b0, 1'b1);

    force_q = '{3'b110};
    run(0, 2, 1'b0, 1'b0);
    force_q = '{3'b100, 3'b010};
    run(0, 2, 1'b0, 1'b0);
    force_q = '{3'b010, 3'b010};
    run(0, 0, 1'b0, 1'b0);
    force_q = '{3'b000};
    run(0, 1, 1'b0, 1'b0);
    force_q = '{3'b100, 3'b111};
    run(2, 77, 1'b1, 1'b0);
    force_q.delete();

    // Reset in the middle of a settle-3 search
    model(8, 200);
    @(negedge clk);
    start_d[2] = 1'b1;
    @(posedge clk);
    #1 start_d[2] = 1'b0;
    fl_d[2] = exp_fl[0];
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("midrst_busy_before", int'(o_busy[2]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    fl_d[2] = 3'b000;
    @(negedge clk);
    chk_zero(2, "midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_stays_idle", int'(o_busy[2]), 0);
    run(2, 200, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 15; i++) begin
        int a;
        a = $urandom_range((1 << n_of[k]) - 1);
        force_q.delete();
        if ($urandom_range(4) == 0) begin
          for (int j = 0; j <= $urandom_range(1); j++) force_q.push_back(3'($urandom_range(7)));
        end
        run(k, a, (s_of[k] > 1) && ($urandom_range(1) == 1), $urandom_range(1) == 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/comparador_search_ctrl.md
Name: comparador_search_ctrl

Overview:
- Sequential controller on the operand/result side of the N-bit magnitude comparator. It drives the comparator's b operand and consumes its gt/lt/eq flags.
- An unknown N-bit value sits on the comparator's a operand. The block binary-searches for it, one comparison per step, and reports the value, the comparison count and an error flag.
- Used by the team to exercise the comparator in hardware and as a reusable successive-approximation search engine.

Parameters:
- N, 8, operand width; must match the comparator instance.
- SETTLE_CYC, 1, cycles guess_out is held stable before flags are sampled; minimum 1.

Ports:
- clk_in  input  1  single clock; all state updates on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  request a new search; sampled only in IDLE.
- gt_in  input  1  comparator flag: a > guess.
- lt_in  input  1  comparator flag: a < guess.
- eq_in  input  1  comparator flag: a == guess.
- guess_out  output  N  registered operand driven to comparator b input.
- busy_out  output  1  high while a search is in progress.
- done_out  output  1  one-cycle pulse when a search terminates.
- result_out  output  N  found value; valid from done_out until the next accepted start.
- steps_out  output  $clog2(N+2)  number of comparisons sampled in the last search.
- error_out  output  1  last search ended in inconsistency; held until the next accepted start.

Behaviour:
- Reset (rst_in=1 at an edge, in any state, including mid-search): state=IDLE; guess_out=0, busy_out=0, done_out=0, result_out=0, steps_out=0, error_out=0; lo=0, hi=2^N-1, wait counter=0.
- lo and hi are internal N+1-bit registers, so hi=lo-1 and lo=2^N never wrap.
- Guess formula: guess = lo + ((hi - lo) >> 1), computed N+1 bits wide and truncated to N.
- States: IDLE, WAIT, DONE.
- IDLE:
  - start_in=1 at an edge: lo=0, hi=2^N-1, guess_out=2^(N-1)-1, steps=0, error_out=0, result_out=0, busy_out=1, counter=SETTLE_CYC-1, next state WAIT.
  - start_in=0: stay in IDLE; all outputs hold.
- WAIT, counter>0: decrement; flags are ignored.
- WAIT, counter==0: sample the flags at this edge and increment steps.
  - Exactly eq_in set: result_out=guess_out, go to DONE.
  - Exactly gt_in set: lo=guess+1.
  - Exactly lt_in set: hi=guess-1.
  - If the new lo>hi (value outside the remaining range): error_out=1, result_out=guess_out, go to DONE.
  - Otherwise: guess_out=new guess, counter=SETTLE_CYC-1, stay in WAIT.
  - Zero flags, or more than one flag set: error_out=1, result_out=guess_out, go to DONE.
- DONE: done_out=1 for exactly this cycle; steps_out=steps; busy_out=0. The next edge returns to IDLE with done_out=0.
- Timing and ordering:
  - Each comparison takes SETTLE_CYC cycles.
  - A consistent search terminates within N+1 comparisons.
  - done_out rises k*SETTLE_CYC cycles after the start edge, where k is the comparison count.
- start_in is ignored while busy_out=1 and during the DONE cycle; no queuing.
- guess_out, result_out, steps_out and error_out hold their values in IDLE.

Test Plan:
- N=2, SETTLE_CYC=1, a=3; pulse start:
  - guess_out sequence 1, 2, 3.
  - done_out high exactly 3 cycles after the start edge, with result_out=3, steps_out=3, error_out=0.
  - busy_out falls together with done_out.
- N=2, a=0: guess sequence 1, 0; result_out=0, steps_out=2, error_out=0.
- N=8, a=127: first guess 127 gives eq; done_out 1 cycle after start; result_out=127, steps_out=1.
- N=8, SETTLE_CYC=3, a=200:
  - guess_out is stable for 3 cycles per step, and flags are sampled only on the 3rd cycle.
  - Glitch the flags to an invalid pattern in the non-sampled cycles; the result must be unaffected: result_out=200, steps_out≤9.
- Fault injection, N=2:
  - Force gt_in=lt_in=1 → error_out=1, steps_out=1, done pulse.
  - Force lt_in at guess 0 (gt at 1, then lt at 2, then lt at... range empty) → error_out=1.
  - Force no flags → error_out=1.
- Assert rst_in during WAIT mid-search: next cycle all outputs are 0 and the state is IDLE. Also assert start_in while busy: ignored, and the search completes with the original result.
